// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit (divider and multiplier).
//   - State encoding for the iterative FSMs.
//   - Default operand and counter widths.
//   - Quotient reported on divide-by-zero.
package mdu_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_CNT_W = 6;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StCalc = CALC,
    StSign = SIGN,
    StFin  = FIN
  } mdu_state_e;

  // Sized wide so that any WIDTH up to 64 can take its low bits.
  localparam logic [63:0] DIV_BY_ZERO_Q = '1;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
//   r      : current partial remainder, always < d
//   q_msb  : next dividend bit shifted into the remainder
//   d      : divisor magnitude
//   r_next : partial remainder after the trial subtract
//   q_bit  : resulting quotient bit
module div_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic             q_bit
);

  // The shifted remainder needs WIDTH+1 bits: with d >= 2^(WIDTH-1) the
  // remainder can have its MSB set, and dropping it would break the compare.
  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] diff;

  always_comb begin
    r_shift = {r, q_msb};
    diff    = r_shift - {1'b0, d};
    // No borrow out of bit WIDTH means r_shift >= d.
    q_bit   = ~diff[WIDTH];
    r_next  = q_bit ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, signed (DIV) and unsigned (DIVU).
// Responds to a one-cycle start pulse and returns quotient/remainder with a
// one-cycle done pulse. Normal latency is WIDTH+2 edges including the
// accepting edge; divide-by-zero completes on the accepting edge itself.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request pulse, sampled only when idle
//   signed_i              : 1 = signed divide, 0 = unsigned
//   dividend, divisor     : operands, sampled with start
//   busy                  : operation in progress (CALC/SIGN)
//   done                  : one-cycle completion pulse
//   div_by_zero           : divisor was zero, valid with done
//   quotient, remainder   : results, held until overwritten
module iter_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;         // partial remainder
  logic [WIDTH-1:0] q_q, q_d;         // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] d_q, d_d;         // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r;
  logic             step_bit;

  div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d = '0;
          r_d   = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            quotient_d  = DIV_BY_ZERO_Q[WIDTH-1:0];
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = StFin;
          end else begin
            // Magnitude of the most negative value is itself, read as unsigned.
            q_d     = (signed_i && dividend[WIDTH-1]) ? -dividend : dividend;
            d_d     = (signed_i && divisor[WIDTH-1])  ? -divisor  : divisor;
            q_neg_d = signed_i & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg_d = signed_i & dividend[WIDTH-1];
            state_d = StCalc;
          end
        end
      end

      StCalc: begin
        r_d   = step_r;
        q_d   = {q_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = StSign;
        end
      end

      StSign: begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        quotient_d  = q_neg_q ? -q_q : q_q;
        remainder_d = r_neg_q ? -r_q : r_q;
        state_d     = StFin;
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  always_comb begin
    busy        = (state_q == StCalc) || (state_q == StSign);
    done        = (state_q == StFin);
    div_by_zero = dbz_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
  end

endmodule
